// File: rtl/read_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : read_fifo_fwft
// Brief    : Read-side pointer/flag controller of an asynchronous FIFO with a
//            first-word-fall-through output stage (main + skid register) and
//            a valid/ready consumer handshake. Runs entirely in clk_r.
// Revision : 1.0 - initial release
// ============================================================================
module read_fifo_fwft #(
    parameter int unsigned fifo_addr_size        = 5,  // RAM address width A
    parameter int unsigned data_size             = 8,  // data word width D
    parameter int unsigned almost_empty_full_gap = 3   // almost_empty threshold
) (
    input  logic                      clk_r,
    input  logic                      rst_r,
    input  logic [fifo_addr_size:0]   waddr_gray_sync,
    output logic [fifo_addr_size:0]   raddr_gray,
    output logic [fifo_addr_size-1:0] r_addr,
    output logic                      mem_rd_en,
    input  logic [data_size-1:0]      r_data,
    output logic [data_size-1:0]      dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [fifo_addr_size:0]   rd_level
);

    // Pointers carry one extra wrap bit so that full (level 2^A) and empty
    // (level 0) are distinguishable.
    localparam int unsigned c_PTR_W = fifo_addr_size + 1;
    localparam logic [c_PTR_W-1:0] c_GAP = c_PTR_W'(almost_empty_full_gap);
    localparam logic [c_PTR_W-1:0] c_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // Pointer and flag state
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]   w_ptr_bin;       // write pointer, binary, read domain
    logic [c_PTR_W-1:0]   r_ptr_bin;       // read pointer, binary
    logic [c_PTR_W-1:0]   w_ptr_next;      // read pointer after one fetch
    logic [c_PTR_W-1:0]   r_raddr_gray;    // read pointer, Gray, exported
    logic [c_PTR_W-1:0]   w_level;         // RAM-resident unfetched entries
    logic                 w_empty;

    // ------------------------------------------------------------------------
    // Output stage state
    // ------------------------------------------------------------------------
    logic [data_size-1:0] r_dout;          // head-of-FIFO word
    logic                 r_dout_valid;
    logic [data_size-1:0] r_skid_data;     // second word, waits behind r_dout
    logic                 r_skid_valid;
    logic                 r_pend;          // RAM read issued last cycle
    logic                 w_pop;           // consumer takes r_dout this cycle
    logic [1:0]           w_occ;           // words held or in flight
    logic [1:0]           w_occ_after_pop; // room check for a new fetch
    logic                 w_fetch;         // issue a RAM read this cycle

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_ptr_bin = '0;
        for (int i = 0; i < c_PTR_W; i++) begin
            w_ptr_bin[i] = ^(waddr_gray_sync >> i);
        end
    end

    // Level and flags follow directly from the two binary pointers; the
    // subtraction wraps naturally in c_PTR_W bits.
    always_comb begin
        w_level    = w_ptr_bin - r_ptr_bin;
        w_empty    = (w_level == '0);
        w_ptr_next = r_ptr_bin + c_ONE;
    end

    // Occupancy bookkeeping: a new fetch is allowed only when, after this
    // cycle's pop, fewer than two words are held or in flight, so the stage
    // never needs more than dout + skid to absorb the returning data.
    always_comb begin
        w_pop           = r_dout_valid & dout_ready;
        w_occ           = {1'b0, r_dout_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend};
        w_occ_after_pop = w_occ - {1'b0, w_pop};
        w_fetch         = !w_empty && (w_occ_after_pop < 2'd2);
    end

    // Read pointer and its Gray image advance together on every fetch, so the
    // exported Gray value changes by exactly one bit per increment.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            r_ptr_bin    <= '0;
            r_raddr_gray <= '0;
        end else if (w_fetch) begin
            r_ptr_bin    <= w_ptr_next;
            r_raddr_gray <= w_ptr_next ^ (w_ptr_next >> 1);
        end
    end

    // Output stage: returning RAM data goes to dout when dout will be free
    // and nothing waits in skid, otherwise to skid; on a pop the skid word
    // moves forward first, which keeps fetch order equal to output order.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_pend       <= 1'b0;
        end else begin
            r_pend <= w_fetch;
            if (w_pop) begin
                if (r_skid_valid) begin
                    r_dout       <= r_skid_data;
                    r_dout_valid <= 1'b1;
                    r_skid_valid <= r_pend;
                    if (r_pend) begin
                        r_skid_data <= r_data;
                    end
                end else if (r_pend) begin
                    r_dout       <= r_data;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_dout_valid <= 1'b0;
                end
            end else if (r_pend) begin
                if (!r_dout_valid) begin
                    r_dout       <= r_data;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_skid_data  <= r_data;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

    // Port mapping; the RAM read strobe is deliberately not gated by reset,
    // since reset clears r_pend and any data returned is ignored.
    always_comb begin
        raddr_gray   = r_raddr_gray;
        r_addr       = r_ptr_bin[fifo_addr_size-1:0];
        mem_rd_en    = w_fetch;
        dout         = r_dout;
        dout_valid   = r_dout_valid;
        empty        = w_empty;
        almost_empty = (w_level < c_GAP);
        rd_level     = w_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_read_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_fifo_fwft
// Brief    : Self-checking bench for read_fifo_fwft. A behavioural write side
//            and registered-output RAM feed the DUT; every written word is
//            queued and compared when the consumer pops it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_fifo_fwft;

    localparam int A   = 5;
    localparam int D   = 8;
    localparam int GAP = 3;
    localparam int PW  = A + 1;

    logic          clk_r = 1'b0;
    logic          rst_r;
    logic [PW-1:0] waddr_gray_sync;
    logic [PW-1:0] raddr_gray;
    logic [A-1:0]  r_addr;
    logic          mem_rd_en;
    logic [D-1:0]  r_data;
    logic [D-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;

    read_fifo_fwft #(
        .fifo_addr_size        (A),
        .data_size             (D),
        .almost_empty_full_gap (GAP)
    ) dut (
        .clk_r           (clk_r),
        .rst_r           (rst_r),
        .waddr_gray_sync (waddr_gray_sync),
        .raddr_gray      (raddr_gray),
        .r_addr          (r_addr),
        .mem_rd_en       (mem_rd_en),
        .r_data          (r_data),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .rd_level        (rd_level)
    );

    always #5 clk_r = ~clk_r;

    // Dual-port RAM read port: data appears the cycle after the strobe.
    logic [D-1:0] mem [0:(1<<A)-1];
    always @(posedge clk_r) begin
        if (mem_rd_en) r_data <= mem[r_addr];
    end

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [D-1:0] exp_q[$];
    int           nreads = 0;
    int           npops  = 0;
    logic [PW-1:0] wptr;
    bit           hold_chk = 1'b0;
    logic [D-1:0] hold_data;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_r);
        #2;
    endtask

    task automatic write_word(input logic [D-1:0] data);
        mem[wptr[A-1:0]] = data;
        exp_q.push_back(data);
        wptr            = wptr + 1'b1;
        waddr_gray_sync = wptr ^ (wptr >> 1);
    endtask

    task automatic apply_reset();
        rst_r           = 1'b1;
        wptr            = '0;
        waddr_gray_sync = '0;
        dout_ready      = 1'b0;
        tick();
        exp_q.delete();
        nreads = 0;
        npops  = 0;
        rst_r  = 1'b0;
        #1;
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle before each edge.
    initial begin
        forever begin
            @(negedge clk_r);
            if (rst_r) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    chk_eq("hold_valid", {31'd0, dout_valid}, 32'd1);
                    chk_eq("hold_data", {24'd0, dout}, {24'd0, hold_data});
                end
                if (mem_rd_en) nreads++;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) chk_eq("pop_unexpected", exp_q.size(), 1);
                    else                   chk_eq("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                    npops++;
                end
                chk_eq("occ_le2", {31'd0, (nreads - npops) <= 2}, 32'd1);
                hold_chk  = dout_valid && !dout_ready;
                hold_data = dout;
            end
        end
    end

    initial begin
        int lvl;
        int written;
        int cyc;
        rst_r           = 1'b1;
        dout_ready      = 1'b0;
        wptr            = '0;
        waddr_gray_sync = '0;

        // Reset values
        tick();
        tick();
        chk_eq("rst_raddr_gray", raddr_gray, 0);
        chk_eq("rst_dout", dout, 0);
        chk_eq("rst_dout_valid", dout_valid, 0);
        chk_eq("rst_mem_rd_en", mem_rd_en, 0);
        chk_eq("rst_empty", empty, 1);
        chk_eq("rst_almost_empty", almost_empty, 1);
        chk_eq("rst_rd_level", rd_level, 0);
        apply_reset();

        // Single word: empty falls, one fetch from address 0
        write_word(8'hA5);
        #1;
        chk_eq("t1_rd_en", mem_rd_en, 1);
        chk_eq("t1_r_addr", r_addr, 0);
        chk_eq("t1_empty", empty, 0);
        chk_eq("t1_level", rd_level, 1);
        tick();
        chk_eq("t1_rd_en_off", mem_rd_en, 0);
        chk_eq("t1_empty_after", empty, 1);
        chk_eq("t1_raddr_gray", raddr_gray, 1);
        chk_eq("t1_valid_pend", dout_valid, 0);
        tick();
        chk_eq("t1_valid", dout_valid, 1);
        chk_eq("t1_dout", dout, 8'hA5);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk_eq("t1_valid_popped", dout_valid, 0);

        // Full RAM, consumer always ready: gapless stream 0..31
        apply_reset();
        for (int i = 0; i < 32; i++) write_word(D'(i));
        dout_ready = 1'b1;
        #1;
        chk_eq("t2_level0", rd_level, 32);
        chk_eq("t2_ae0", almost_empty, 0);
        chk_eq("t2_rd_en0", mem_rd_en, 1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            lvl = (k <= 32) ? 32 - k : 0;
            chk_eq("t2_level", rd_level, lvl);
            chk_eq("t2_ae", almost_empty, (lvl < GAP) ? 1 : 0);
            chk_eq("t2_empty", empty, (lvl == 0) ? 1 : 0);
            if (k >= 2 && k <= 33) chk_eq("t2_no_gap", dout_valid, 1);
            if (k == 32) chk_eq("t2_raddr_gray", raddr_gray, 6'b110000);
            if (k == 34) chk_eq("t2_valid_end", dout_valid, 0);
        end
        chk_eq("t2_drained", exp_q.size(), 0);
        dout_ready = 1'b0;

        // Backpressure: only two fetches while stalled, then one word per cycle
        apply_reset();
        for (int i = 0; i < 4; i++) write_word(D'(8'h10 + i));
        repeat (5) tick();
        chk_eq("t3_level", rd_level, 2);
        chk_eq("t3_reads", nreads, 2);
        chk_eq("t3_valid", dout_valid, 1);
        chk_eq("t3_dout", dout, 8'h10);
        chk_eq("t3_rd_en", mem_rd_en, 0);
        dout_ready = 1'b1;
        #1;
        chk_eq("t3_stream0", dout_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("t3_stream", dout_valid, 1);
        end
        tick();
        chk_eq("t3_valid_end", dout_valid, 0);
        chk_eq("t3_drained", exp_q.size(), 0);

        // Random backpressure, 100 words across pointer wrap
        written = 0;
        cyc     = 0;
        while ((written < 100 || exp_q.size() != 0) && cyc < 3000) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (written < 100 && exp_q.size() < 32 && $urandom_range(0, 3) != 0) begin
                write_word(D'($urandom));
                written++;
            end
            tick();
            cyc++;
        end
        dout_ready = 1'b0;
        chk_eq("t4_written", written, 100);
        chk_eq("t4_drained", exp_q.size(), 0);

        // Reset with dout and skid both occupied
        apply_reset();
        for (int i = 0; i < 4; i++) write_word(D'(8'h30 + i));
        repeat (3) tick();
        chk_eq("t5_valid_pre", dout_valid, 1);
        rst_r           = 1'b1;
        wptr            = '0;
        waddr_gray_sync = '0;
        tick();
        chk_eq("t5_valid", dout_valid, 0);
        chk_eq("t5_raddr_gray", raddr_gray, 0);
        chk_eq("t5_rd_en", mem_rd_en, 0);
        chk_eq("t5_empty", empty, 1);
        chk_eq("t5_level", rd_level, 0);
        exp_q.delete();
        nreads = 0;
        npops  = 0;
        rst_r  = 1'b0;
        tick();
        chk_eq("t5_valid_after", dout_valid, 0);

        // almost_empty threshold: level 3 -> 2
        for (int i = 0; i < 5; i++) write_word(D'(8'h20 + i));
        repeat (4) tick();
        chk_eq("t6_level3", rd_level, 3);
        chk_eq("t6_ae_low", almost_empty, 0);
        dout_ready = 1'b1;
        #1;
        chk_eq("t6_rd_en", mem_rd_en, 1);
        tick();
        dout_ready = 1'b0;
        #1;
        chk_eq("t6_level2", rd_level, 2);
        chk_eq("t6_ae_high", almost_empty, 1);
        dout_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk_eq("t6_drained", exp_q.size(), 0);
        dout_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
